// File: rtl/hpm_counters_pipe.sv
// rtl/hpm_counters_pipe.sv - Zihpm/Sscofpmf performance counters with a registered event stage
// Counters 3..HPM_NUM_COUNTERS+2, multi-bit event increments, sticky LCOFIP and scountovf.
module hpm_counters_pipe #(
    parameter int CSR_ADDR_WIDTH      = 12,
    parameter int XLEN                = 64,
    parameter int HPM_NUM_COUNTERS    = 29,
    parameter int HPM_NUM_EVENTS      = 28,
    parameter int HPM_COUNTER_WIDTH   = 64,
    parameter int HPM_EVENT_INC_WIDTH = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rstn_i,
    input  logic [CSR_ADDR_WIDTH-1:0]                     addr_i,
    input  logic                                          we_i,
    input  logic [XLEN-1:0]                               data_i,
    output logic [XLEN-1:0]                               data_o,
    input  logic [31:0]                                   mcountinhibit_i,
    input  logic [1:0]                                    priv_lvl_i,
    input  logic [HPM_NUM_EVENTS*HPM_EVENT_INC_WIDTH-1:0] events_i,
    input  logic                                          lcofi_clr_i,
    output logic                                          count_ovf_int_req_o,
    output logic [31:0]                                   scountovf_o
);

    localparam int FIRST = 3;
    localparam int LAST  = HPM_NUM_COUNTERS + 2;
    localparam int CW    = HPM_COUNTER_WIDTH;
    localparam int W     = HPM_EVENT_INC_WIDTH;
    localparam int SEL_W = $clog2(HPM_NUM_EVENTS + 1);
    localparam int NTAB  = 1 << SEL_W;

    if (XLEN != 64) begin : g_xlen_check
        $error("hpm_counters_pipe supports only XLEN = 64");
    end
    if (HPM_NUM_COUNTERS < 1 || HPM_NUM_COUNTERS > 29 || CW < 32 || CW > 64) begin : g_range_check
        $error("hpm_counters_pipe parameter out of range");
    end

    logic [CW-1:0]    counter_q [FIRST:LAST];
    logic [W-1:0]     inc_q     [FIRST:LAST];
    logic [W-1:0]     inc_d     [FIRST:LAST];
    logic [SEL_W-1:0] sel_q     [FIRST:LAST];
    logic [CW:0]      sum       [FIRST:LAST];
    logic [LAST:FIRST] of_q, minh_q, sinh_q, uinh_q;
    logic [LAST:FIRST] cnt_hit, evt_hit, cnt_wr, evt_wr, new_ovf;
    logic              lcofip_q;

    // Selector-indexed increment table; SEL 0 and SEL > HPM_NUM_EVENTS map to zero.
    logic [W-1:0] ev_tab [NTAB];
    for (genvar k = 0; k < NTAB; k++) begin : g_ev
        if (k >= 1 && k <= HPM_NUM_EVENTS) begin : g_src
            assign ev_tab[k] = events_i[(k-1)*W +: W];
        end else begin : g_zero
            assign ev_tab[k] = '0;
        end
    end

    always_comb begin
        for (int i = FIRST; i <= LAST; i++) begin
            logic inh;
            cnt_hit[i] = (addr_i == CSR_ADDR_WIDTH'(32'hB00 + i));
            evt_hit[i] = (addr_i == CSR_ADDR_WIDTH'(32'h320 + i));
            cnt_wr[i]  = we_i && cnt_hit[i];
            evt_wr[i]  = we_i && evt_hit[i];
            inh = (priv_lvl_i == 2'b11 && minh_q[i]) ||
                  (priv_lvl_i == 2'b01 && sinh_q[i]) ||
                  (priv_lvl_i == 2'b00 && uinh_q[i]);
            inc_d[i] = (!mcountinhibit_i[i] && !inh) ? ev_tab[sel_q[i]] : '0;
            sum[i]   = {1'b0, counter_q[i]} + (CW+1)'(inc_q[i]);
            // A software write to the counter swallows this cycle's add and its carry.
            new_ovf[i] = sum[i][CW] && !of_q[i] && !cnt_wr[i];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = FIRST; i <= LAST; i++) begin
                counter_q[i] <= '0;
                inc_q[i]     <= '0;
                sel_q[i]     <= '0;
            end
            of_q     <= '0;
            minh_q   <= '0;
            sinh_q   <= '0;
            uinh_q   <= '0;
            lcofip_q <= 1'b0;
        end else begin
            for (int i = FIRST; i <= LAST; i++) begin
                inc_q[i] <= inc_d[i];
                if (cnt_wr[i]) begin
                    counter_q[i] <= data_i[CW-1:0];
                end else begin
                    counter_q[i] <= sum[i][CW-1:0];
                end
                if (evt_wr[i]) begin
                    of_q[i]   <= data_i[63] | new_ovf[i];
                    minh_q[i] <= data_i[62];
                    sinh_q[i] <= data_i[61];
                    uinh_q[i] <= data_i[60];
                    sel_q[i]  <= data_i[SEL_W-1:0];
                end else if (new_ovf[i]) begin
                    of_q[i] <= 1'b1;
                end
            end
            if (|new_ovf) begin
                lcofip_q <= 1'b1;
            end else if (lcofi_clr_i) begin
                lcofip_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data_o      = '0;
        scountovf_o = '0;
        for (int i = FIRST; i <= LAST; i++) begin
            scountovf_o[i] = of_q[i];
            if (cnt_hit[i]) begin
                data_o[CW-1:0] = counter_q[i];
            end
            if (evt_hit[i]) begin
                data_o[63]         = of_q[i];
                data_o[62]         = minh_q[i];
                data_o[61]         = sinh_q[i];
                data_o[60]         = uinh_q[i];
                data_o[SEL_W-1:0]  = sel_q[i];
            end
        end
    end

    assign count_ovf_int_req_o = lcofip_q;

    logic unused_bits;
    assign unused_bits = ^{data_i, mcountinhibit_i};

endmodule
